// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the N-voice sample-playback mixer.
//   mix_state_e  - mixer sequencer states
//   REG_*        - per-voice register offsets (address = ch*4 + offset)
//   CTRL_*       - bit positions inside the CTRL register
//   sat_dw()     - clamp a wide signed value into a dw-bit two's complement range
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ACC   = 3'd3,
    OUT   = 3'd4
  } mix_state_e;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_START = 2'd1;
  localparam logic [1:0] REG_END   = 2'd2;
  localparam logic [1:0] REG_VOL   = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;

  // Works on a 64-bit carrier so any accumulator width up to 64 can use it;
  // the caller truncates the result to dw bits.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/audio_voice_regs.sv
// audio_voice_regs: register file and playback state for one voice.
//   i_clk, i_reset       clock, async active-high reset
//   i_wr                 qualified bus write (chipselect & write)
//   i_address            register index; this voice owns address CH*4..CH*4+3
//   i_writedata          write data; bit CH is used by the shared IRQ_CLR register
//   i_fetch              mixer is in FETCH for this voice (activates a pending start)
//   i_advance            mixer is in ACC for this voice (advance / wrap / finish)
//   o_active, o_start_pend, o_irq_pend, o_ptr, o_start_addr, o_vol  state to the mixer
module audio_voice_regs
  import audio_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CH        = 0,
  parameter int SAMPLE_AW = 17,
  parameter int VOL_W     = 8,
  parameter int AW        = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [AW-1:0]        i_address,
  input  logic [15:0]          i_writedata,
  input  logic                 i_fetch,
  input  logic                 i_advance,
  output logic                 o_active,
  output logic                 o_start_pend,
  output logic                 o_irq_pend,
  output logic [SAMPLE_AW-1:0] o_ptr,
  output logic [SAMPLE_AW-1:0] o_start_addr,
  output logic [VOL_W-1:0]     o_vol
);

  logic [SAMPLE_AW-1:0] r_start;
  logic [SAMPLE_AW-1:0] r_end;
  logic [SAMPLE_AW-1:0] r_ptr;
  logic [VOL_W-1:0]     r_vol;
  logic                 r_loop;
  logic                 r_active;
  logic                 r_pend;
  logic                 r_irq;

  logic                 w_sel;
  logic                 w_ctrl_wr;
  logic                 w_start_cmd;
  logic                 w_stop_cmd;
  logic                 w_irq_clr;
  logic [SAMPLE_AW-1:0] w_wd_addr;

  assign w_sel       = i_wr && (i_address < AW'(NUM_CH * 4)) &&
                       (i_address[AW-1:2] == (AW-2)'(CH));
  assign w_ctrl_wr   = w_sel && (i_address[1:0] == REG_CTRL);
  assign w_stop_cmd  = w_ctrl_wr && i_writedata[CTRL_STOP];
  assign w_start_cmd = w_ctrl_wr && i_writedata[CTRL_START] && !i_writedata[CTRL_STOP];
  assign w_irq_clr   = i_wr && (i_address == AW'(NUM_CH * 4)) && i_writedata[CH];
  assign w_wd_addr   = SAMPLE_AW'(i_writedata);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_start  <= '0;
      r_end    <= '0;
      r_ptr    <= '0;
      r_vol    <= '0;
      r_loop   <= 1'b0;
      r_active <= 1'b0;
      r_pend   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr)                                     r_loop  <= i_writedata[CTRL_LOOP];
      if (w_sel && (i_address[1:0] == REG_START))        r_start <= w_wd_addr;
      if (w_sel && (i_address[1:0] == REG_END))          r_end   <= w_wd_addr;
      if (w_sel && (i_address[1:0] == REG_VOL))          r_vol   <= i_writedata[VOL_W-1:0];

      // Clear first so a same-cycle end-of-sample set takes priority.
      if (w_irq_clr) r_irq <= 1'b0;

      if (i_fetch && r_pend) begin
        r_ptr    <= r_start;
        r_active <= 1'b1;
        r_pend   <= 1'b0;
      end

      if (i_advance && r_active) begin
        if (r_ptr == r_end) begin
          if (r_loop) begin
            r_ptr <= r_start;
          end else begin
            r_active <= 1'b0;
            r_irq    <= 1'b1;
          end
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end

      // A fresh START re-arms even if the fetch consumed the old one this cycle;
      // STOP is applied last so it overrides everything.
      if (w_start_cmd) r_pend <= 1'b1;
      if (w_stop_cmd) begin
        r_active <= 1'b0;
        r_pend   <= 1'b0;
      end
    end
  end

  assign o_active     = r_active;
  assign o_start_pend = r_pend;
  assign o_irq_pend   = r_irq;
  assign o_ptr        = r_ptr;
  assign o_start_addr = r_start;
  assign o_vol        = r_vol;

endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: N-voice sample-playback mixer sharing one sample ROM port.
//   i_clk, i_reset        clock, async active-high reset
//   i_chipselect/i_write  write-only host bus strobes
//   i_address/i_writedata register index (ch*4+r, NUM_CH*4 = IRQ_CLR) and data
//   o_irq                 OR of per-voice finished flags
//   i_sample_req          codec request; starts one mix when idle
//   o_audio_output        saturated mix, held between updates
//   o_rom_addr, i_rom_q   shared ROM port, data valid ROM_LAT cycles after address
//
// state | meaning
// IDLE  | waiting for sample_req
// FETCH | activate pending start, issue ROM address for voice r_ch
// WAIT  | ROM_LAT cycles for ROM data
// ACC   | scale and accumulate voice r_ch, advance its pointer
// OUT   | saturate accumulator onto audio_output
module audio_mixer
  import audio_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DW        = 16,
  parameter int SAMPLE_AW = 17,
  parameter int ROM_LAT   = 1,
  parameter int VOL_W     = 8
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_chipselect,
  input  logic                               i_write,
  input  logic [$clog2(NUM_CH*4+1)-1:0]      i_address,
  input  logic [15:0]                        i_writedata,
  output logic                               o_irq,
  input  logic                               i_sample_req,
  output logic [DW-1:0]                      o_audio_output,
  output logic [SAMPLE_AW-1:0]               o_rom_addr,
  input  logic [DW-1:0]                      i_rom_q
);

  localparam int AW    = $clog2(NUM_CH * 4 + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = DW + VOL_W + $clog2(NUM_CH) + 1;
  localparam int PW    = DW + VOL_W + 1;

  mix_state_e                r_state;
  logic [CH_W-1:0]           r_ch;
  logic [1:0]                r_wait;
  logic                      r_cur_act;
  logic signed [ACC_W-1:0]   r_acc;
  logic [SAMPLE_AW-1:0]      r_rom_addr;
  logic [DW-1:0]             r_out;

  logic [NUM_CH-1:0]         w_active;
  logic [NUM_CH-1:0]         w_pend;
  logic [NUM_CH-1:0]         w_irq_pend;
  logic [SAMPLE_AW-1:0]      w_ptr   [NUM_CH];
  logic [SAMPLE_AW-1:0]      w_start [NUM_CH];
  logic [VOL_W-1:0]          w_vol   [NUM_CH];

  logic                      w_wr;
  logic                      w_fetch_en;
  logic                      w_acc_en;
  logic                      w_last_ch;
  logic                      w_contrib;
  logic signed [PW-1:0]      w_a;
  logic signed [PW-1:0]      w_b;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_scaled;
  logic signed [ACC_W-1:0]   w_scaled_ext;

  assign w_wr       = i_chipselect && i_write;
  assign w_fetch_en = (r_state == FETCH);
  assign w_acc_en   = (r_state == ACC);
  assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
    audio_voice_regs #(
      .NUM_CH   (NUM_CH),
      .CH       (g),
      .SAMPLE_AW(SAMPLE_AW),
      .VOL_W    (VOL_W),
      .AW       (AW)
    ) u_regs (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_wr        (w_wr),
      .i_address   (i_address),
      .i_writedata (i_writedata),
      .i_fetch     (w_fetch_en && (r_ch == CH_W'(g))),
      .i_advance   (w_acc_en && (r_ch == CH_W'(g))),
      .o_active    (w_active[g]),
      .o_start_pend(w_pend[g]),
      .o_irq_pend  (w_irq_pend[g]),
      .o_ptr       (w_ptr[g]),
      .o_start_addr(w_start[g]),
      .o_vol       (w_vol[g])
    );
  end

  // Volume is unsigned: zero-extend before the signed multiply. The product of
  // a DW-bit sample and a (VOL_W+1)-bit positive gain always fits in PW bits.
  assign w_a          = {{(VOL_W + 1){i_rom_q[DW-1]}}, i_rom_q};
  assign w_b          = {{DW{1'b0}}, 1'b0, w_vol[r_ch]};
  assign w_prod       = w_a * w_b;
  assign w_scaled     = w_prod >>> 7;
  assign w_scaled_ext = ACC_W'(w_scaled);

  // A STOP that lands between FETCH and ACC still removes the voice.
  assign w_contrib    = r_cur_act && w_active[r_ch];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_wait     <= '0;
      r_cur_act  <= 1'b0;
      r_acc      <= '0;
      r_rom_addr <= '0;
      r_out      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_sample_req) begin
            r_state <= FETCH;
            r_ch    <= '0;
            r_acc   <= '0;
          end
        end
        FETCH: begin
          r_cur_act <= w_active[r_ch] || w_pend[r_ch];
          if (w_pend[r_ch])        r_rom_addr <= w_start[r_ch];
          else if (w_active[r_ch]) r_rom_addr <= w_ptr[r_ch];
          r_wait  <= 2'(ROM_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wait == 2'd0) r_state <= ACC;
          else                r_wait  <= r_wait - 2'd1;
        end
        ACC: begin
          if (w_contrib) r_acc <= r_acc + w_scaled_ext;
          if (w_last_ch) begin
            r_state <= OUT;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= FETCH;
          end
        end
        OUT: begin
          r_out   <= DW'(sat_dw(64'(r_acc), DW));
          r_acc   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_audio_output = r_out;
  assign o_rom_addr     = r_rom_addr;
  assign o_irq          = |w_irq_pend;

endmodule

// File: tb/tb_audio_mixer.sv
module tb_audio_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  address = '0;
  logic [15:0] writedata = '0;
  logic        irq;
  logic        sample_req = 1'b0;
  logic [15:0] audio_output;
  logic [16:0] rom_addr;
  logic [15:0] rom_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Ramp ROM with one cycle of latency: mem[a] = a (low 16 bits).
  always @(posedge clk) rom_q <= rom_addr[15:0];

  audio_mixer dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_chipselect  (chipselect),
    .i_write       (write),
    .i_address     (address),
    .i_writedata   (writedata),
    .o_irq         (irq),
    .i_sample_req  (sample_req),
    .o_audio_output(audio_output),
    .o_rom_addr    (rom_addr),
    .i_rom_q       (rom_q)
  );

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic cfg_voice(input int ch, input logic [15:0] s, input logic [15:0] e,
                           input logic [15:0] v, input logic [15:0] ctrl);
    bus_write(5'(ch * 4 + 1), s);
    bus_write(5'(ch * 4 + 2), e);
    bus_write(5'(ch * 4 + 3), v);
    bus_write(5'(ch * 4), ctrl);
  endtask

  task automatic stop_all();
    for (int c = 0; c < 4; c++) bus_write(5'(c * 4), 16'h0004);
    bus_write(5'd16, 16'h000F);
  endtask

  // Leaves time at 1 ns after the edge that samples the request.
  task automatic pulse_req();
    @(posedge clk); #1 sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b0;
  endtask

  task automatic do_mix(output logic [15:0] v);
    pulse_req();
    repeat (13) @(posedge clk);
    #1 v = audio_output;
  endtask

  task automatic test_reset();
    n_tests++;
    if (audio_output !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h want 0000", audio_output); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_tests++;
    if (rom_addr !== 17'h0) begin n_fail++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
  endtask

  task automatic test_oneshot();
    logic [15:0] exp_v [4] = '{16'd10, 16'd11, 16'd12, 16'd0};
    logic        exp_i [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] v;
    cfg_voice(0, 16'd10, 16'd12, 16'd128, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      do_mix(v);
      n_tests++;
      if (v !== exp_v[k]) begin n_fail++; $display("FAIL oneshot_out[%0d] got %0d want %0d", k, v, exp_v[k]); end
      n_tests++;
      if (irq !== exp_i[k]) begin n_fail++; $display("FAIL oneshot_irq[%0d] got %b want %b", k, irq, exp_i[k]); end
    end
    bus_write(5'd16, 16'h0001);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_loop();
    logic [15:0] exp_v [5] = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11};
    logic [15:0] v;
    bus_write(5'd0, 16'h0003);
    for (int k = 0; k < 5; k++) begin
      do_mix(v);
      n_tests++;
      if (v !== exp_v[k]) begin n_fail++; $display("FAIL loop_out[%0d] got %0d want %0d", k, v, exp_v[k]); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL loop_irq[%0d] got %b want 0", k, irq); end
    end
    stop_all();
  endtask

  task automatic test_mix();
    logic [15:0] v;
    // 100*64/128 = 50, 200*128/128 = 200, -10*64/128 = -5 -> 245
    cfg_voice(0, 16'd100, 16'd100, 16'd64, 16'h0003);
    cfg_voice(1, 16'd200, 16'd200, 16'd128, 16'h0003);
    cfg_voice(2, 16'hFFF6, 16'hFFF6, 16'd64, 16'h0003);
    do_mix(v);
    n_tests++;
    if (v !== 16'd245) begin n_fail++; $display("FAIL mix_scaled got %0d want 245", v); end
    stop_all();
  endtask

  task automatic test_saturate();
    logic [15:0] v;
    for (int c = 0; c < 4; c++) cfg_voice(c, 16'h7000, 16'h7000, 16'd255, 16'h0003);
    do_mix(v);
    n_tests++;
    if (v !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos got %h want 7fff", v); end
    for (int c = 0; c < 4; c++) cfg_voice(c, 16'h9000, 16'h9000, 16'd255, 16'h0003);
    do_mix(v);
    n_tests++;
    if (v !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got %h want 8000", v); end
    stop_all();
  endtask

  task automatic test_start_stop();
    logic [15:0] v;
    cfg_voice(1, 16'd300, 16'd300, 16'd128, 16'h0005);
    do_mix(v);
    n_tests++;
    if (v !== 16'd0) begin n_fail++; $display("FAIL start_stop_same got %0d want 0", v); end
    cfg_voice(2, 16'd20, 16'd20, 16'd128, 16'h0003);
    bus_write(5'd4, 16'h0003);
    do_mix(v);
    n_tests++;
    if (v !== 16'd320) begin n_fail++; $display("FAIL two_voice got %0d want 320", v); end
    bus_write(5'd4, 16'h0004);
    do_mix(v);
    n_tests++;
    if (v !== 16'd20) begin n_fail++; $display("FAIL stop_excl got %0d want 20", v); end
    stop_all();
  endtask

  task automatic test_latency();
    logic [15:0] v;
    cfg_voice(2, 16'd20, 16'd25, 16'd128, 16'h0003);
    do_mix(v);
    n_tests++;
    if (v !== 16'd20) begin n_fail++; $display("FAIL lat_first got %0d want 20", v); end
    pulse_req();                       // edge E0 samples request
    repeat (5) @(posedge clk);
    #1 sample_req = 1'b1;              // second request during the mix
    @(posedge clk); #1 sample_req = 1'b0;
    repeat (6) @(posedge clk);         // edge E12
    #1;
    n_tests++;
    if (audio_output !== 16'd20) begin n_fail++; $display("FAIL lat_early got %0d want 20", audio_output); end
    @(posedge clk); #1;                // edge E13
    n_tests++;
    if (audio_output !== 16'd21) begin n_fail++; $display("FAIL lat_13 got %0d want 21", audio_output); end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (audio_output !== 16'd21) begin n_fail++; $display("FAIL req_ignored got %0d want 21", audio_output); end
    do_mix(v);
    n_tests++;
    if (v !== 16'd22) begin n_fail++; $display("FAIL lat_next got %0d want 22", v); end
    stop_all();
  endtask

  task automatic test_reset_mid_mix();
    logic [15:0] v;
    cfg_voice(3, 16'd40, 16'd40, 16'd128, 16'h0001);
    do_mix(v);
    n_tests++;
    if (v !== 16'd40 || irq !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got out=%0d irq=%b want out=40 irq=1", v, irq);
    end
    cfg_voice(0, 16'd10, 16'd12, 16'd128, 16'h0003);
    pulse_req();
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (audio_output !== 16'h0 || irq !== 1'b0 || rom_addr !== 17'h0) begin
      n_fail++; $display("FAIL mid_reset got out=%h irq=%b addr=%h want 0/0/0", audio_output, irq, rom_addr);
    end
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (audio_output !== 16'h0) begin n_fail++; $display("FAIL no_partial got %h want 0", audio_output); end
    cfg_voice(0, 16'd50, 16'd50, 16'd128, 16'h0001);
    do_mix(v);
    n_tests++;
    if (v !== 16'd50) begin n_fail++; $display("FAIL post_reset got %0d want 50", v); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_oneshot();
    test_loop();
    test_mix();
    test_saturate();
    test_start_stop();
    test_latency();
    test_reset_mid_mix();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
